// File: rtl/bks_iter_mult_if.sv
`default_nettype none
// ============================================================================
// Module   : bks_iter_mult_if
// Brief    : Operand/result handshake bundle for the iterative carry-less
//            Karatsuba multiplier.
// Revision : 1.0
// ============================================================================
interface bks_iter_mult_if #(
  parameter int W = 16
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-2:0] out_p;
  logic           busy;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_p, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_p, busy
  );
endinterface
`default_nettype wire

// File: rtl/bks_iter_mult.sv
`default_nettype none
// ============================================================================
// Module   : bks_iter_mult
// Brief    : Iterative one-level GF(2)[x] Karatsuba multiplier; a single
//            half-width carry-less array is reused for the three sub-products.
// Revision : 1.0
// ============================================================================
module bks_iter_mult #(
  parameter int W = 16
) (
  input  wire logic      clk,
  input  wire logic      rst,
  bks_iter_mult_if.slave bus
);

  localparam int H  = W / 2;
  localparam int PW = 2 * W - 1;

  if ((W % 2) != 0 || W < 4) begin : g_bad_width
    $error("bks_iter_mult: W must be even and >= 4");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LO   = 3'd1,
    S_HI   = 3'd2,
    S_MID  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-2:0]    r_lo;
  logic [W-2:0]    r_hi;
  logic [PW-1:0]   r_p;

  logic [H-1:0]    w_ma;
  logic [H-1:0]    w_mb;
  logic [W-2:0]    w_prod;
  logic [W-2:0]    w_cross;
  logic [PW-1:0]   w_res;
  logic            w_accept;

  assign w_accept = (r_state == S_IDLE) && bus.in_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid) w_next = S_LO;
      S_LO:    w_next = S_HI;
      S_HI:    w_next = S_MID;
      S_MID:   w_next = S_DONE;
      S_DONE:  if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Shared multiplier operands: the MID step folds the halves before multiplying.
  always_comb begin
    w_ma = '0;
    w_mb = '0;
    case (r_state)
      S_LO: begin
        w_ma = r_a[H-1:0];
        w_mb = r_b[H-1:0];
      end
      S_HI: begin
        w_ma = r_a[W-1:H];
        w_mb = r_b[W-1:H];
      end
      S_MID: begin
        w_ma = r_a[H-1:0] ^ r_a[W-1:H];
        w_mb = r_b[H-1:0] ^ r_b[W-1:H];
      end
      default: begin
        w_ma = '0;
        w_mb = '0;
      end
    endcase
  end

  always_comb begin
    w_prod = '0;
    for (int i = 0; i < H; i++) begin
      if (w_mb[i]) begin
        w_prod = w_prod ^ ({{(H-1){1'b0}}, w_ma} << i);
      end
    end
  end

  // Karatsuba recombination; the XOR of all three products is the cross term.
  assign w_cross = r_lo ^ r_hi ^ w_prod;
  assign w_res   = {{W{1'b0}}, r_lo}
                 ^ ({{W{1'b0}}, w_cross} << H)
                 ^ ({{W{1'b0}}, r_hi} << W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a  <= '0;
      r_b  <= '0;
      r_lo <= '0;
      r_hi <= '0;
      r_p  <= '0;
    end else begin
      if (w_accept) begin
        r_a <= bus.in_a;
        r_b <= bus.in_b;
      end
      if (r_state == S_LO) begin
        r_lo <= w_prod;
      end
      if (r_state == S_HI) begin
        r_hi <= w_prod;
      end
      if (r_state == S_MID) begin
        r_p <= w_res;
      end
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.out_p     = r_p;

endmodule
`default_nettype wire

// File: tb/tb_bks_iter_mult.sv
`default_nettype none
// ============================================================================
// Module   : tb_bks_iter_mult
// Brief    : Self-checking bench: vector table, directed corner sequences and
//            random scoreboard regression at W = 4, 8, 16, 32.
// Revision : 1.0
// ============================================================================
module tb_bks_iter_mult;

  localparam int W = 16;
  localparam int N_RAND = 2500;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic grst = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int rdy_mode = 2;  // 0 random, 1 always ready, 2 never ready
  logic [2*W-2:0] q[$];
  bit gdone [3];

  bks_iter_mult_if #(.W(W)) bus ();
  bks_iter_mult #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  function automatic logic [63:0] clmul_ref(input logic [31:0] a, input logic [31:0] b, input int w);
    logic [63:0] r = '0;
    for (int i = 0; i < w; i++)
      if (b[i]) r = r ^ ({32'd0, a} << i);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic r;
    logic [2*W-2:0] e;
    case (rdy_mode)
      0:       r = ($urandom_range(0, 3) != 0);
      1:       r = 1'b1;
      default: r = 1'b0;
    endcase
    if (bus.out_valid && r) begin
      n_vec++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_output: got %h with nothing expected", bus.out_p);
      end else begin
        e = q.pop_front();
        if (bus.out_p !== e) begin
          n_bad++;
          $display("FAIL result: got %h expected %h", bus.out_p, e);
        end
      end
    end
    bus.out_ready = r;
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2*W-2:0] exp, input bit push);
    int g = 0;
    @(negedge clk);
    while (!bus.in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!bus.in_ready) begin
      chk("send_timeout", 0, 1);
      return;
    end
    bus.in_a = a;
    bus.in_b = b;
    bus.in_valid = 1'b1;
    if (push) q.push_back(exp);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_a = W'($urandom);
    bus.in_b = W'($urandom);
  endtask

  task automatic drain();
    int g = 0;
    while (q.size() != 0 && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", 64'(q.size()), 0);
      q.delete();
    end
  endtask

  task automatic wait_valid();
    int g = 0;
    while (!bus.out_valid && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("wait_out_valid", 64'(bus.out_valid), 1);
  endtask

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-2:0] exp;
  } vec_t;

  initial begin
    vec_t tbl [8];
    logic [63:0] t;
    logic [2*W-2:0] hold;
    logic [W-1:0] ra, rb;
    int sent, g;

    tbl[0] = '{16'h0003, 16'h0003, 31'h0000_0005};
    tbl[1] = '{16'hFFFF, 16'h0001, 31'h0000_FFFF};
    tbl[2] = '{16'h00FF, 16'h0101, 31'h0000_FFFF};
    tbl[3] = '{16'h0007, 16'h0007, 31'h0000_0015};
    tbl[4] = '{16'h8000, 16'h8000, 31'h4000_0000};
    tbl[5] = '{16'hFFFF, 16'hFFFF, 31'h5555_5555};
    tbl[6] = '{16'h0000, 16'hABCD, 31'h0000_0000};
    tbl[7] = '{16'h1234, 16'h0001, 31'h0000_1234};

    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    grst = 1'b0;

    chk("reset_in_ready", 64'(bus.in_ready), 1);
    chk("reset_out_valid", 64'(bus.out_valid), 0);
    chk("reset_busy", 64'(bus.busy), 0);
    chk("reset_out_p", 64'(bus.out_p), 0);

    // Latency: accept on E0, out_valid visible after E3.
    rdy_mode = 2;
    send(16'h0003, 16'h0003, '0, 1'b0);
    chk("lo_in_ready", 64'(bus.in_ready), 0);
    chk("lo_busy", 64'(bus.busy), 1);
    chk("lo_out_valid", 64'(bus.out_valid), 0);
    @(negedge clk);
    chk("hi_out_valid", 64'(bus.out_valid), 0);
    @(negedge clk);
    chk("mid_out_valid", 64'(bus.out_valid), 0);
    chk("mid_busy", 64'(bus.busy), 1);
    @(negedge clk);
    chk("done_out_valid", 64'(bus.out_valid), 1);
    chk("done_out_p", 64'(bus.out_p), 64'h5);
    chk("done_in_ready", 64'(bus.in_ready), 0);
    chk("done_busy", 64'(bus.busy), 1);
    q.push_back(31'h5);
    rdy_mode = 1;
    drain();
    @(negedge clk);
    chk("post_done_in_ready", 64'(bus.in_ready), 1);
    chk("post_done_out_valid", 64'(bus.out_valid), 0);

    for (int i = 0; i < 8; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].exp, 1'b1);
      drain();
    end

    // Back-pressure: result held 10 cycles while stray in_valid pulses arrive.
    rdy_mode = 2;
    t = clmul_ref(32'h0000_BEEF, 32'h0000_1357, W);
    send(16'hBEEF, 16'h1357, t[2*W-2:0], 1'b1);
    wait_valid();
    hold = bus.out_p;
    chk("bp_first_value", 64'(hold), 64'(t[2*W-2:0]));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = i[0];
      bus.in_a = W'($urandom);
      bus.in_b = W'($urandom);
      chk("bp_out_valid", 64'(bus.out_valid), 1);
      chk("bp_out_p_stable", 64'(bus.out_p), 64'(hold));
    end
    bus.in_valid = 1'b0;
    rdy_mode = 1;
    drain();
    send(16'h0005, 16'h0003, 31'h0000_000F, 1'b1);
    drain();

    // Asynchronous reset while the HI step is in progress.
    send(16'hABCD, 16'h1234, '0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 64'(bus.out_valid), 0);
    chk("abort_out_p", 64'(bus.out_p), 0);
    chk("abort_busy", 64'(bus.busy), 0);
    chk("abort_in_ready", 64'(bus.in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    send(16'h0002, 16'h0003, 31'h0000_0006, 1'b1);
    drain();
    repeat (6) @(negedge clk);
    chk("abort_no_stale_valid", 64'(bus.out_valid), 0);

    rdy_mode = 0;
    sent = 0;
    g = 0;
    while (sent < N_RAND && g < 40000) begin
      @(negedge clk);
      g++;
      if (bus.in_ready && $urandom_range(0, 3) != 0) begin
        ra = W'($urandom);
        rb = W'($urandom);
        bus.in_a = ra;
        bus.in_b = rb;
        bus.in_valid = 1'b1;
        t = clmul_ref(32'(ra), 32'(rb), W);
        q.push_back(t[2*W-2:0]);
        sent++;
      end else begin
        bus.in_valid = !bus.in_ready && ($urandom_range(0, 1) == 1);
        bus.in_a = W'($urandom);
        bus.in_b = W'($urandom);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("rand_w16_sent", 64'(sent), 64'(N_RAND));
    drain();

    g = 0;
    while (!(gdone[0] && gdone[1] && gdone[2]) && g < 40000) begin
      @(negedge clk);
      g++;
    end
    chk("rand_all_widths_done", 64'(gdone[0] && gdone[1] && gdone[2]), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_rand
    localparam int GW = (gi == 0) ? 4 : ((gi == 1) ? 8 : 32);

    bks_iter_mult_if #(.W(GW)) gbus ();
    bks_iter_mult #(.W(GW)) gdut (.clk(clk), .rst(grst), .bus(gbus.slave));

    logic [2*GW-2:0] gq[$];

    always @(negedge clk) begin
      logic r;
      logic [2*GW-2:0] e;
      r = ($urandom_range(0, 3) != 0);
      if (gbus.out_valid && r) begin
        n_vec++;
        if (gq.size() == 0) begin
          n_bad++;
          $display("FAIL rand_w%0d_unexpected: got %h with nothing expected", GW, gbus.out_p);
        end else begin
          e = gq.pop_front();
          if (gbus.out_p !== e) begin
            n_bad++;
            $display("FAIL rand_w%0d_result: got %h expected %h", GW, gbus.out_p, e);
          end
        end
      end
      gbus.out_ready = r;
    end

    initial begin
      int sent = 0;
      int g = 0;
      logic [63:0] t;
      logic [GW-1:0] a, b;
      gbus.in_valid = 1'b0;
      gbus.in_a = '0;
      gbus.in_b = '0;
      wait (!grst);
      while (sent < N_RAND && g < 40000) begin
        @(negedge clk);
        g++;
        if (gbus.in_ready && $urandom_range(0, 3) != 0) begin
          a = GW'($urandom);
          b = GW'($urandom);
          gbus.in_a = a;
          gbus.in_b = b;
          gbus.in_valid = 1'b1;
          t = clmul_ref(32'(a), 32'(b), GW);
          gq.push_back(t[2*GW-2:0]);
          sent++;
        end else begin
          gbus.in_valid = !gbus.in_ready && ($urandom_range(0, 1) == 1);
          gbus.in_a = GW'($urandom);
          gbus.in_b = GW'($urandom);
        end
      end
      @(negedge clk);
      gbus.in_valid = 1'b0;
      g = 0;
      while (gq.size() != 0 && g < 300) begin
        @(negedge clk);
        g++;
      end
      n_vec++;
      if (sent < N_RAND || gq.size() != 0) begin
        n_bad++;
        $display("FAIL rand_w%0d_incomplete: sent %0d pending %0d", GW, sent, gq.size());
      end
      gdone[gi] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: doc/bks_iter_mult.md
# bks_iter_mult

Parametrised, iterative, one-level binary (carry-less, GF(2)[x]) Karatsuba multiplier with valid/ready handshakes on input and output. It is the generalised successor of the fixed 8-bit combinational binary Karatsuba cells. One shared half-width carry-less product array is time-multiplexed over the three Karatsuba sub-products. The block sits in the multiplier library for datapaths where area matters more than throughput, and produces the unreduced 2W-1-bit polynomial product.

## Interface
- W, default 16: operand width in bits; must be even and >= 4. H = W/2.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand pair present on in_a/in_b.
- in_ready  out  1  block can accept operands; 1 only in IDLE.
- in_a  in  W  operand A; bit i is the coefficient of x^i.
- in_b  in  W  operand B; same encoding as in_a.
- out_valid  out  1  out_p holds a valid product.
- out_ready  in  1  downstream accepts out_p.
- out_p  out  2W-1  carry-less product A·B over GF(2).
- busy  out  1  1 in any state other than IDLE.

## Operation
- Math: Al/Bl = low H bits, Ah/Bh = high H bits. m_lo = Al·Bl, m_hi = Ah·Bh, m_mid = (Al^Ah)·(Bl^Bh); each product is 2H-1 = W-1 bits, computed with XOR/AND only and no carries. Result: p = m_lo ^ ((m_lo^m_hi^m_mid) << H) ^ (m_hi << W), truncated to 2W-1 bits (the upper bits are zero by construction).
- One combinational H×H carry-less multiplier; its inputs are muxed by state.
- Registers: the operand registers (2W), the m_lo and m_hi registers (W-1 each), the result register (2W-1) and the state register.
- FSM states: IDLE, LO, HI, MID, DONE.
  - IDLE: in_ready=1. When in_valid=1, register in_a/in_b and go to LO. Otherwise stay in IDLE.
  - LO: m_lo <= mult(Al,Bl); go to HI.
  - HI: m_hi <= mult(Ah,Bh); go to MID.
  - MID: compute m_mid; result register <= combination formula using m_lo, m_hi and m_mid; go to DONE.
  - DONE: out_valid=1. When out_ready=1, go to IDLE. Otherwise hold, with out_p stable.
- in_valid is ignored outside IDLE. Operands are captured only on the accept edge, so in_a/in_b may change freely afterwards.
- No same-cycle output-accept/input-accept overlap: DONE→IDLE first, then a new accept.
- out_p holds the last result after the handshake until the next MID overwrites it. out_p is only meaningful while out_valid=1.

## Timing
- Reset values: state=IDLE, out_valid=0, out_p=0, busy=0, in_ready=1, all internal registers 0.
- Reset asserted in any state aborts the operation asynchronously. The partial result is discarded, and no out_valid pulse is produced after reset.
- Acceptance on edge E0, where in_valid and in_ready are both 1.
  - LO occupies cycle E0→E1, HI occupies E1→E2, MID occupies E2→E3.
  - out_valid rises after edge E3, so latency is 3 cycles from accept edge to out_valid.
- With out_ready held at 1: the handshake completes at edge E4 and in_ready=1 after E4, so the next accept can occur at E5. Maximum throughput is one product per 5 cycles.
- Back-pressure: out_valid and out_p stay constant while out_ready=0, for any number of cycles.
- in_ready and out_valid are decoded from registered state only. There is no combinational path from in_valid or out_ready to any output.

## Test plan
- Reset, then W=16: apply in_a=0x0003, in_b=0x0003, in_valid=1 → accepted on the first edge; out_valid rises 3 cycles later with out_p=0x00000005; in_ready=0 and busy=1 during LO/HI/MID/DONE.
- W=16 carry-free identity and cross-term cases: 0xFFFF·0x0001 → 0x0000FFFF; 0x00FF·0x0101 → 0x0000FFFF; 0x0007·0x0007 → 0x00000015; 0x8000·0x8000 → 0x40000000 (top bit 2W-2).
- Back-pressure: hold out_ready=0 for 10 cycles in DONE → out_valid=1 and out_p constant throughout; in_valid pulses are ignored; release → IDLE, then a new accept works.
- Reset mid-operation: assert rst during HI with operands 0xABCD·0x1234 → out_valid=0 and out_p=0 immediately; after release, 0x0002·0x0003 yields 0x00000006 with no stale result.
- Random regression, W ∈ {4, 8, 16, 32}: ≥10k random pairs with random in_valid/out_ready gaps, compared against a reference shift-XOR carry-less model; every accepted operand produces exactly one result, in order.
